s_key_scheduler: RTL and testbench

RC4 key-scheduling stage (KSA swap loop). It runs after the S-array initializer has written s[i]=i into the 256x8 S memory.
On start it iterates i=0..255, computing j = j + s[i] + key[i mod KEY_LEN] and swapping s[i] and s[j] through a single-port RAM interface. It pulses done when finished so the PRGA/decrypt stage can begin. It shares the S-memory port with the initializer through an external mux.

---
 rtl/s_key_scheduler_if.sv | 21 ++
 rtl/s_key_scheduler.sv | 141 ++++++++++++++
 tb/tb_s_key_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_key_scheduler_if.sv
// S-memory port and control bundle for the RC4 key-scheduling stage.
// The master side is the scheduler; the slave side is the RAM/controller environment.
interface s_key_scheduler_if;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        s_mem_wren;
  logic        done;

  modport master (
    input  start, secret_key, q,
    output address, data, s_mem_wren, done
  );

  modport slave (
    output start, secret_key, q,
    input  address, data, s_mem_wren, done
  );
endinterface

// File: rtl/s_key_scheduler.sv
// RC4 KSA swap loop over a 256x8 single-port S memory with registered address.
// Optional macro KSA_SKIP_EQUAL_EN skips the read/swap of s[j] when j equals i.
module s_key_scheduler #(
  parameter int unsigned KEY_LEN = 3
) (
  input logic                clk,
  input logic                rst,
  s_key_scheduler_if.master  mem_bus
);

  typedef enum logic [3:0] {
    StIdle, StRdI, StWtI, StRdJ, StWtJ, StWrI, StWrJ, StNext, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [23:0] key_q, key_d;

  logic [7:0]  key_byte;
  logic [7:0]  j_sum;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        wren;
  logic        done_pulse;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 2'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    case (k_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  assign j_sum = j_q + mem_bus.q + key_byte;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    key_d      = key_q;
    addr       = 8'd0;
    wdata      = 8'd0;
    wren       = 1'b0;
    done_pulse = 1'b0;

    case (state_q)
      StIdle: begin
        if (mem_bus.start) begin
          key_d   = mem_bus.secret_key;
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 2'd0;
          state_d = StRdI;
        end
      end
      StRdI: begin
        addr    = i_q;
        state_d = StWtI;
      end
      StWtI: begin
        addr    = i_q;
        si_d    = mem_bus.q;
        j_d     = j_sum;
`ifdef KSA_SKIP_EQUAL_EN
        state_d = (j_sum == i_q) ? StNext : StRdJ;
`else
        state_d = StRdJ;
`endif
      end
      StRdJ: begin
        addr    = j_q;
        state_d = StWtJ;
      end
      StWtJ: begin
        addr    = j_q;
        sj_d    = mem_bus.q;
        state_d = StWrI;
      end
      StWrI: begin
        addr    = i_q;
        wdata   = sj_q;
        wren    = 1'b1;
        state_d = StWrJ;
      end
      // Written last so an i==j swap leaves the original value in place.
      StWrJ: begin
        addr    = j_q;
        wdata   = si_q;
        wren    = 1'b1;
        state_d = StNext;
      end
      StNext: begin
        if (i_q == 8'hFF) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == 2'(KEY_LEN - 1)) ? 2'd0 : k_q + 2'd1;
          state_d = StRdI;
        end
      end
      StDone: begin
        done_pulse = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_bus.address    = addr;
  assign mem_bus.data       = wdata;
  assign mem_bus.s_mem_wren = wren;
  assign mem_bus.done       = done_pulse;

endmodule

// File: tb/tb_s_key_scheduler.sv
// Directed bench for s_key_scheduler: RAM models, write logs and an RC4 KSA reference model.
module tb_s_key_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  s_key_scheduler_if bus ();
  s_key_scheduler_if bus1 ();

  s_key_scheduler #(.KEY_LEN(3)) dut (.clk(clk), .rst(rst), .mem_bus(bus.master));
  s_key_scheduler #(.KEY_LEN(1)) dut1 (.clk(clk), .rst(rst), .mem_bus(bus1.master));

  logic [7:0] mem [256];
  logic [7:0] mem1 [256];
  logic [7:0] gold [256];
  logic [7:0] gold_j [256];
  logic [7:0] q_r, q1_r;
  logic       init_id = 1'b0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done1_cnt = 0;
  logic [7:0] log_a [$];
  logic [7:0] log_d [$];
  int         log_c [$];
  logic [7:0] log1_a [$];
  logic [7:0] log1_d [$];
  int         checks = 0;
  int         errors = 0;

  assign bus.q  = q_r;
  assign bus1.q = q1_r;

  // Registered-address RAMs; every write is logged with the cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_id) begin
      for (int n = 0; n < 256; n++) begin
        mem[n]  <= 8'(n);
        mem1[n] <= 8'(n);
      end
    end else begin
      if (bus.s_mem_wren) begin
        mem[bus.address] <= bus.data;
        log_a.push_back(bus.address);
        log_d.push_back(bus.data);
        log_c.push_back(cyc);
      end
      if (bus1.s_mem_wren) begin
        mem1[bus1.address] <= bus1.data;
        log1_a.push_back(bus1.address);
        log1_d.push_back(bus1.data);
      end
    end
    q_r  <= mem[bus.address];
    q1_r <= mem1[bus1.address];
    if (bus.done)  done_cnt  <= done_cnt + 1;
    if (bus1.done) done1_cnt <= done1_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_identity();
    init_id = 1'b1;
    step();
    init_id = 1'b0;
  endtask

  task automatic model_ksa(input int klen, input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int n = 0; n < 256; n++) gold[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = ((n % klen) == 0) ? key[23:16] : ((n % klen) == 1) ? key[15:8] : key[7:0];
      j = j + gold[n] + kb;
      gold_j[n] = j;
      t = gold[n];
      gold[n] = gold[j];
      gold[j] = t;
    end
  endtask

  function automatic int first_diff(input bit which);
    for (int n = 0; n < 256; n++) begin
      if ((which ? mem1[n] : mem[n]) !== gold[n]) return n;
    end
    return -1;
  endfunction

  // Pulses start for one edge; returns the counter value seen during the first RD_I cycle.
  task automatic launch(input bit which, output int s0);
    if (which) bus1.start = 1'b1; else bus.start = 1'b1;
    step();
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    s0 = cyc;
  endtask

  // Returns the cycle number (1 = first RD_I) in which done is high, or -1 on timeout.
  task automatic wait_done(input bit which, input int s0, output int lat);
    lat = -1;
    for (int n = 0; n < 4000; n++) begin
      if (which ? bus1.done : bus.done) begin
        lat = cyc - s0 + 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;  bus.secret_key = 24'd0;
    bus1.start = 1'b0; bus1.secret_key = 24'd0;
    rst = 1'b0;
    step(); step(); step();
    checks++;
    if ({bus.address, bus.data, bus.s_mem_wren, bus.done} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h data=%h wren=%b done=%b expected all 0",
               bus.address, bus.data, bus.s_mem_wren, bus.done);
    end
    checks++;
    if ({bus1.address, bus1.data, bus1.s_mem_wren, bus1.done} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs_k1 got addr=%h data=%h wren=%b done=%b expected all 0",
               bus1.address, bus1.data, bus1.s_mem_wren, bus1.done);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_identity_zero();
`ifdef KSA_SKIP_EQUAL_EN
    logic [7:0] exp_a [2] = '{8'd2, 8'd3};
    logic [7:0] exp_d [2] = '{8'd3, 8'd2};
    int         exp_c [2] = '{11, 12};
    int         nexp = 2;
`else
    logic [7:0] exp_a [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd5};
    logic [7:0] exp_d [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd5, 8'd2};
    int         exp_c [8] = '{5, 6, 12, 13, 19, 20, 26, 27};
    int         nexp = 8;
`endif
    int s0, lat, base, dc, bad;
    init_identity();
    bus.secret_key = 24'h000000;
    base = log_a.size();
    dc = done_cnt;
    launch(1'b0, s0);
    wait_done(1'b0, s0, lat);
`ifdef KSA_SKIP_EQUAL_EN
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL zero_latency got %0d expected done before timeout", lat);
    end
`else
    checks++;
    if (lat !== 1793) begin
      errors++;
      $display("FAIL zero_latency got %0d expected 1793", lat);
    end
`endif
    step();
    checks++;
    if (bus.done !== 1'b0 || done_cnt !== dc + 1) begin
      errors++;
      $display("FAIL zero_done_once got done=%b count=%0d expected done=0 count=%0d",
               bus.done, done_cnt - dc, 1);
    end
    for (int n = 0; n < nexp; n++) begin
      checks++;
      if (log_a.size() <= base + n) begin
        errors++;
        $display("FAIL zero_write%0d got no write expected addr=%h data=%h", n, exp_a[n], exp_d[n]);
      end else if (log_a[base+n] !== exp_a[n] || log_d[base+n] !== exp_d[n] ||
                   log_c[base+n] - s0 + 1 !== exp_c[n]) begin
        errors++;
        $display("FAIL zero_write%0d got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 n, log_a[base+n], log_d[base+n], log_c[base+n] - s0 + 1,
                 exp_a[n], exp_d[n], exp_c[n]);
      end
    end
    model_ksa(3, 24'h000000);
    bad = first_diff(1'b0);
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL zero_final_s idx %0d got %h expected %h", bad, mem[bad], gold[bad]);
    end
  endtask

  task automatic test_key_0302ab();
    int s0, lat, base, bad;
    init_identity();
    bus.secret_key = 24'h0302AB;
    base = log_a.size();
    launch(1'b0, s0);
    wait_done(1'b0, s0, lat);
    step();
    model_ksa(3, 24'h0302AB);
    checks++;
    if (gold_j[0] !== 8'h03 || gold_j[1] !== 8'h06 || gold_j[2] !== 8'hB3) begin
      errors++;
      $display("FAIL key_model_j got %h %h %h expected 03 06 b3", gold_j[0], gold_j[1], gold_j[2]);
    end
`ifndef KSA_SKIP_EQUAL_EN
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (log_a.size() <= base + 2 * n + 1 || log_a[base+2*n+1] !== gold_j[n]) begin
        errors++;
        $display("FAIL key_j_iter%0d got %h expected %h", n,
                 (log_a.size() > base + 2 * n + 1) ? log_a[base+2*n+1] : 8'hxx, gold_j[n]);
      end
    end
`endif
    bad = first_diff(1'b0);
    checks++;
    if (lat < 0 || bad >= 0) begin
      errors++;
      $display("FAIL key_final_s lat=%0d idx %0d got %h expected %h", lat, bad,
               (bad >= 0) ? mem[bad] : 8'h00, (bad >= 0) ? gold[bad] : 8'h00);
    end
  endtask

  task automatic test_midrun_reset();
    int s0, lat, nlog, dc;
    init_identity();
    bus.secret_key = 24'h0302AB;
    launch(1'b0, s0);
    for (int n = 1; n < 705; n++) step();
`ifndef KSA_SKIP_EQUAL_EN
    checks++;
    if (bus.s_mem_wren !== 1'b1 || bus.address !== 8'd100) begin
      errors++;
      $display("FAIL rst_position got wren=%b addr=%h expected wren=1 addr=64",
               bus.s_mem_wren, bus.address);
    end
`endif
    rst = 1'b0;
    step();
    checks++;
    if (bus.s_mem_wren !== 1'b0 || bus.address !== 8'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_midrun got wren=%b addr=%h done=%b expected 0 00 0",
               bus.s_mem_wren, bus.address, bus.done);
    end
    rst = 1'b1;
    nlog = log_a.size();
    dc = done_cnt;
    for (int n = 0; n < 20; n++) step();
    checks++;
    if (log_a.size() !== nlog || done_cnt !== dc) begin
      errors++;
      $display("FAIL rst_quiet got writes=%0d dones=%0d expected 0 0", log_a.size() - nlog,
               done_cnt - dc);
    end
    launch(1'b0, s0);
    wait_done(1'b0, s0, lat);
    step();
`ifdef KSA_SKIP_EQUAL_EN
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL rst_rerun_latency got %0d expected done before timeout", lat);
    end
`else
    checks++;
    if (lat !== 1793) begin
      errors++;
      $display("FAIL rst_rerun_latency got %0d expected 1793", lat);
    end
`endif
  endtask

  task automatic test_busy_start_key_change();
    int s0, lat, dc, nlog, bad;
    init_identity();
    bus.secret_key = 24'h1A2B3C;
    dc = done_cnt;
    bus.start = 1'b1;
    step();
    s0 = cyc;
    lat = -1;
    for (int n = 1; n < 4000; n++) begin
      if (n == 50) bus.secret_key = 24'hFFFFFF;
      if (bus.done) begin
        lat = n;
        bus.start = 1'b0;
        break;
      end
      step();
    end
    bus.start = 1'b0;
    nlog = log_a.size();
    for (int n = 0; n < 30; n++) step();
    checks++;
    if (done_cnt !== dc + 1 || log_a.size() !== nlog) begin
      errors++;
      $display("FAIL busy_single_run got dones=%0d extra_writes=%0d expected 1 0",
               done_cnt - dc, log_a.size() - nlog);
    end
`ifndef KSA_SKIP_EQUAL_EN
    checks++;
    if (lat !== 1793) begin
      errors++;
      $display("FAIL busy_latency got %0d expected 1793", lat);
    end
`endif
    model_ksa(3, 24'h1A2B3C);
    bad = first_diff(1'b0);
    checks++;
    if (lat < 0 || bad >= 0) begin
      errors++;
      $display("FAIL busy_final_s lat=%0d idx %0d got %h expected %h", lat, bad,
               (bad >= 0) ? mem[bad] : 8'h00, (bad >= 0) ? gold[bad] : 8'h00);
    end
  endtask

  task automatic test_keylen1_wrap();
    logic [7:0] exp_a [4] = '{8'h00, 8'hFF, 8'h01, 8'hFF};
    logic [7:0] exp_d [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};
    int s0, lat, base, bad;
    init_identity();
    bus1.secret_key = 24'hFF1234;
    base = log1_a.size();
    launch(1'b1, s0);
    wait_done(1'b1, s0, lat);
    step();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (log1_a.size() <= base + n || log1_a[base+n] !== exp_a[n] ||
          log1_d[base+n] !== exp_d[n]) begin
        errors++;
        $display("FAIL k1_write%0d got addr=%h data=%h expected addr=%h data=%h", n,
                 (log1_a.size() > base + n) ? log1_a[base+n] : 8'hxx,
                 (log1_a.size() > base + n) ? log1_d[base+n] : 8'hxx, exp_a[n], exp_d[n]);
      end
    end
    model_ksa(1, 24'hFF1234);
    bad = first_diff(1'b1);
    checks++;
    if (lat < 0 || bad >= 0) begin
      errors++;
      $display("FAIL k1_final_s lat=%0d idx %0d got %h expected %h", lat, bad,
               (bad >= 0) ? mem1[bad] : 8'h00, (bad >= 0) ? gold[bad] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_identity_zero();
    test_key_0302ab();
    test_midrun_reset();
    test_busy_start_key_change();
    test_keylen1_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
